fifo_wr_arbiter: RTL

Single-clock round-robin arbiter that shares the write port of the asynchronous FIFO (FIFO_Async_top) among NREQ requesters in the wrClk domain. It grants one requester at a time for bursts of up to BURST words and drives wrEn/wrData directly into the FIFO. It stalls on fifoFull and passes ownership fairly without idle cycles between grants.

---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the FIFO write port: grants one requester at a time for
// bursts of up to BURST words and forwards its data straight into wrEn/wrData.
`timescale 1ns/1ps

module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                wrClk_i,
    input  logic                wrRst_i,
    input  logic [NREQ-1:0]     reqValid_i,
    input  logic [NREQ*DW-1:0]  reqData_i,
    output logic [NREQ-1:0]     reqReady_o,
    input  logic                fifoFull_i,
    output logic                wrEn_o,
    output logic [DW-1:0]       wrData_o,
    output logic                grantValid_o,
    output logic [IDW-1:0]      grantId_o,
    output logic [15:0]         xferCount_o
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q,      state_d;
    logic [IDW-1:0]  owner_q,      owner_d;
    logic [IDW-1:0]  last_owner_q, last_owner_d;
    logic [BW-1:0]   burst_cnt_q,  burst_cnt_d;
    logic [15:0]     xfer_count_q, xfer_count_d;

    logic [DW-1:0]   req_data_arr [NREQ];
    logic [IDW-1:0]  cand_id      [NREQ];
    logic [NREQ-1:0] cand_valid;
    logic [IDW-1:0]  pick_base;
    logic [IDW-1:0]  pick_id;
    logic            any_valid;
    logic            grant;
    logic            owner_valid;
    logic            wr_en;
    logic            release_grant;

    // A release searches from the current owner, which is about to become lastOwner.
    assign pick_base = (state_q == GRANT) ? owner_q : last_owner_q;
    assign any_valid = |reqValid_i;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign req_data_arr[gi] = reqData_i[gi*DW +: DW];
            assign sum              = {1'b0, pick_base} + (IDW+1)'(gi + 1);
            assign cand_id[gi]      = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                              : sum[IDW-1:0];
            assign cand_valid[gi]   = reqValid_i[cand_id[gi]];
        end
    endgenerate

    // Candidate 0 is nearest after the base, so scanning downward leaves the closest.
    always_comb begin
        pick_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                pick_id = cand_id[k];
            end
        end
    end

    always_ff @(posedge wrClk_i or posedge wrRst_i) begin
        if (wrRst_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDW'(NREQ - 1);
            burst_cnt_q  <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        burst_cnt_d   = burst_cnt_q;
        xfer_count_d  = xfer_count_q + {15'd0, wr_en};
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d     = GRANT;
                    owner_d     = pick_id;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                release_grant = ~owner_valid | (wr_en & (burst_cnt_q == BURST_LAST));
                if (release_grant) begin
                    last_owner_d = owner_q;
                    burst_cnt_d  = '0;
                    if (any_valid) begin
                        owner_d = pick_id;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant        = (state_q == GRANT);
        owner_valid  = reqValid_i[owner_q];
        wr_en        = grant & owner_valid & ~fifoFull_i;
        reqReady_o   = '0;
        if (wr_en) begin
            reqReady_o[owner_q] = 1'b1;
        end
        wrEn_o       = wr_en;
        wrData_o     = wr_en ? req_data_arr[owner_q] : '0;
        grantValid_o = grant;
        grantId_o    = grant ? owner_q : '0;
        xferCount_o  = xfer_count_q;
    end

endmodule
